multicycle_controller: RTL and testbench

Sequencing FSM for the multi-cycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal). Shares one memory, one ALU and the register file across 3–5 cycles per instruction by driving the datapath's mux selects and write enables each cycle. Includes the main FSM, the immediate-type decoder and the ALU-control decoder. It replaces the single-cycle control path when the core is built multi-cycle.

---
 rtl/multicycle_controller.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RV32I control FSM with immediate and ALU-control decode (optional MC_ILLEGAL_TRAP_EN: unknown opcodes trap to HALT)
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     state_q;
    state_t     state_d;
    logic       pc_update;
    logic       branch;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;
    logic [1:0] alu_op;

    // Only funct7[5] distinguishes add/sub; the rest of the field is ignored.
    logic       unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // State register; reset lands in FETCH immediately, aborting any instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and Moore datapath controls for the current state.
    always_comb begin
        state_d       = S_FETCH;
        pc_update     = 1'b0;
        branch        = 1'b0;
        AdrSrc        = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        alu_op        = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                pc_update    = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Immediate format follows the opcode in every state.
    always_comb begin
        ImmSrc = 2'b00;
        case (opcode)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // ALU operation: add for address/PC math, sub for beq, funct-decoded for ALU ops.
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (opcode[5] & funct7[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Write enables are gated by reset so an asserted reset kills them in the same cycle.
    assign PCWrite  = rst_n & (pc_update | (branch & Zero));
    assign MemWrite = rst_n & mem_write_raw;
    assign IRWrite  = rst_n & ir_write_raw;
    assign RegWrite = rst_n & reg_write_raw;
    assign State    = state_q;

`ifdef MC_ILLEGAL_TRAP_EN
    assign Illegal = (state_q == S_HALT);
`else
    assign Illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] State;

    logic [20:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    event        sample_ev;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .Illegal(Illegal), .State(State)
    );

    always #5 clk = ~clk;

    // Expected outputs for a given state and inputs, taken from the state table.
    function automatic logic [20:0] exp_out(input int st, input logic [6:0] o, input logic [2:0] f3,
                                            input logic [6:0] f7, input logic z, input logic rst);
        logic pcu, br, adr, mw, irw, rw, ill, pcw;
        logic [1:0] rs, sa, sb, aop, imm;
        logic [2:0] ac;
        logic [3:0] s4;
        pcu = 0; br = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
        rs = 0; sa = 0; sb = 0; aop = 0; imm = 0; ac = 0;
        s4 = st[3:0];
        case (st)
            0:  begin irw = 1; sb = 2; rs = 2; pcu = 1; end
            1:  begin sa = 1; sb = 1; end
            2:  begin sa = 2; sb = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2; aop = 2; end
            7:  begin sa = 2; sb = 1; aop = 2; end
            8:  rw = 1;
            9:  begin sa = 2; aop = 1; br = 1; end
            10: begin sa = 1; sb = 2; pcu = 1; end
`ifdef MC_ILLEGAL_TRAP_EN
            11: ill = 1;
`endif
            default: ;
        endcase
        if (o == 7'b0100011) imm = 1;
        else if (o == 7'b1100011) imm = 2;
        else if (o == 7'b1101111) imm = 3;
        if (aop == 1) ac = 3'b001;
        else if (aop == 2) begin
            if (f3 == 3'b000) ac = (o[5] && f7[5]) ? 3'b001 : 3'b000;
            else if (f3 == 3'b010) ac = 3'b101;
            else if (f3 == 3'b110) ac = 3'b011;
            else if (f3 == 3'b111) ac = 3'b010;
        end
        pcw = pcu | (br & z);
        if (rst) begin
            pcw = 0; mw = 0; irw = 0; rw = 0;
        end
        return {s4, pcw, adr, mw, irw, rs, sa, sb, ac, imm, rw, ill};
    endfunction

    task automatic push(input logic [20:0] e, input string nm);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: compares DUT outputs against the oldest pending expectation.
    always begin
        @(negedge clk or sample_ev);
        if (exp_q.size() > 0) begin
            logic [20:0] act;
            logic [20:0] e;
            string nm;
            act = {State, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                   ALUControl, ImmSrc, RegWrite, Illegal};
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got state=%0d vec=%h expected state=%0d vec=%h",
                         nm, act[20:17], act, e[20:17], e);
            end
        end
    end

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            push(exp_out(0, opcode, funct3, funct7, Zero, 1'b1), $sformatf("reset c%0d", i));
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
    endtask

    // One instruction: seq holds the expected state per cycle as nibbles, oldest first.
    task automatic run_instr(input string nm, input logic [6:0] op, input logic [6:0] alt,
                             input logic [2:0] f3, input logic [6:0] f7, input logic z,
                             input logic [47:0] seq, input int n);
        for (int i = 0; i < n; i++) begin
            int st;
            logic [6:0] o;
            st = int'(seq[4*(n-1-i) +: 4]);
            o  = (st == 1 || st == 2) ? op : alt;
            opcode = o; funct3 = f3; funct7 = f7; Zero = z;
            push(exp_out(st, o, f3, f7, z, 1'b0), $sformatf("%s c%0d", nm, i));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; opcode = 7'b0000011; funct3 = 3'b010; funct7 = 7'b0; Zero = 1'b0;
        @(posedge clk); #1;
        do_reset(2);
        run_instr("lw",       7'b0000011, 7'b0000011, 3'b010, 7'b0000000, 0, 48'h01234, 5);
        run_instr("lw_opchg", 7'b0000011, 7'b0110011, 3'b010, 7'b0000000, 0, 48'h01234, 5);
        run_instr("sw",       7'b0100011, 7'b0100011, 3'b010, 7'b0000000, 0, 48'h0125, 4);
        run_instr("r_add",    7'b0110011, 7'b0110011, 3'b000, 7'b0000000, 0, 48'h0168, 4);
        run_instr("r_sub",    7'b0110011, 7'b0110011, 3'b000, 7'b0100000, 0, 48'h0168, 4);
        run_instr("r_slt",    7'b0110011, 7'b0110011, 3'b010, 7'b0000000, 0, 48'h0168, 4);
        run_instr("r_or",     7'b0110011, 7'b0110011, 3'b110, 7'b0000000, 0, 48'h0168, 4);
        run_instr("r_and",    7'b0110011, 7'b0110011, 3'b111, 7'b0000000, 0, 48'h0168, 4);
        run_instr("addi_f7",  7'b0010011, 7'b0010011, 3'b000, 7'b0100000, 0, 48'h0178, 4);
        run_instr("beq_z1",   7'b1100011, 7'b1100011, 3'b000, 7'b0000000, 1, 48'h019, 3);
        run_instr("beq_z0",   7'b1100011, 7'b1100011, 3'b000, 7'b0000000, 0, 48'h019, 3);
        run_instr("jal",      7'b1101111, 7'b1101111, 3'b000, 7'b0000000, 0, 48'h01A8, 4);
`ifdef MC_ILLEGAL_TRAP_EN
        run_instr("illegal",  7'b1111111, 7'b1111111, 3'b000, 7'b0000000, 0, 48'h01BBBBBBBBBB, 12);
`else
        run_instr("illegal",  7'b1111111, 7'b1111111, 3'b000, 7'b0000000, 0, 48'h01, 2);
`endif
        do_reset(1);
        run_instr("sw_part",  7'b0100011, 7'b0100011, 3'b010, 7'b0000000, 0, 48'h012, 3);
        opcode = 7'b0100011;
        push(exp_out(5, opcode, funct3, funct7, Zero, 1'b0), "sw_memwrite");
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        push(exp_out(0, opcode, funct3, funct7, Zero, 1'b1), "sw_abort");
        ->sample_ev;
        @(posedge clk); #1;
        do_reset(1);
        run_instr("post_rst", 7'b0110011, 7'b0110011, 3'b000, 7'b0100000, 0, 48'h0168, 4);
        @(negedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
